// File: rtl/disp_pkg.sv
// Shared constants, types and helpers for the multiplexed 4-digit display scanner.
package disp_pkg;

    localparam int unsigned DIGITS     = 4;
    localparam int unsigned BIN_W      = 14;
    localparam int unsigned MAX_VAL    = 9999;
    localparam int unsigned NIB_W      = 4;
    localparam int unsigned ACC_W      = DIGITS * NIB_W;
    localparam int unsigned IDX_W      = $clog2(DIGITS);
    localparam int unsigned STEP_W     = $clog2(BIN_W);
    localparam logic [3:0]  BLANK_CODE = 4'hF;

    typedef logic [NIB_W-1:0]         nibble_t;
    typedef nibble_t [DIGITS-1:0]     digit_arr_t;

    // Double-dabble correction: bump a nibble by 3 when it would overflow on the next shift.
    function automatic nibble_t add3(input nibble_t n);
        return (n >= nibble_t'(5)) ? n + nibble_t'(3) : n;
    endfunction

endpackage

// File: rtl/disp_scan_if.sv
// Load/result bus between the value source and the display scanner.
interface disp_scan_if;
    import disp_pkg::*;

    logic [BIN_W-1:0] value;
    logic             load;
    logic             busy;
    logic [3:0]       bcd;
    logic             ce;
    logic [DIGITS-1:0] an;

    modport master (output value, load, input busy, bcd, ce, an);
    modport slave  (input value, load, output busy, bcd, ce, an);

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one bit per cycle (BIN_W cycles).
// done and digits are combinational: they present the final result during the last
// busy cycle so the caller can capture it on the same edge at which busy falls.
module bin2bcd_seq
    import disp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output digit_arr_t       digits
);

    logic [BIN_W-1:0]  shreg;
    digit_arr_t        acc;
    digit_arr_t        acc_nxt;
    logic [ACC_W-1:0]  adj_flat;
    logic [STEP_W-1:0] step;

    // One conversion step: correct every nibble, then shift the next binary MSB in.
    always_comb begin
        adj_flat = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            adj_flat[i*NIB_W +: NIB_W] = add3(acc[i]);
        end
        acc_nxt = digit_arr_t'((adj_flat << 1) | ACC_W'(shreg[BIN_W-1]));
        done    = busy && (step == STEP_W'(BIN_W - 1));
        digits  = acc_nxt;
    end

    // Conversion sequencer; start is ignored while a conversion is running.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            step  <= '0;
            shreg <= '0;
            acc   <= '0;
        end else if (busy) begin
            acc   <= acc_nxt;
            shreg <= shreg << 1;
            step  <= step + STEP_W'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end else if (start) begin
            busy  <= 1'b1;
            step  <= '0;
            shreg <= bin;
            acc   <= '0;
        end
    end

endmodule

// File: rtl/disp_scan.sv
// Binary-to-decimal 4-digit multiplexed display scanner.
// Optional build macro DISP_SCAN_BLANK_EN: replaces leading-zero digits with the blank code.
module disp_scan
    import disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
)
(
    input  logic        clk,
    input  logic        rst,
    disp_scan_if.slave  bus
);

    localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [BIN_W-1:0]  clamped;
    logic              conv_busy;
    logic              conv_done;
    digit_arr_t        conv_digits;
    digit_arr_t        disp;
    digit_arr_t        shown;
    logic [PRE_W-1:0]  pre;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_nxt;
    logic [3:0]        bcd_q;
    logic              ce_q;
    logic [DIGITS-1:0] an_q;

    assign clamped = (bus.value > BIN_W'(MAX_VAL)) ? BIN_W'(MAX_VAL) : bus.value;
    assign idx_nxt = idx + IDX_W'(1);

    bin2bcd_seq u_conv (
        .clk    (clk),
        .rst    (rst),
        .start  (bus.load),
        .bin    (clamped),
        .busy   (conv_busy),
        .done   (conv_done),
        .digits (conv_digits)
    );

    // Display digits change only when a full conversion completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp <= '0;
        end else if (conv_done) begin
            disp <= conv_digits;
        end
    end

    // Digit codes as presented to the decoder (optionally with leading zeros blanked).
    always_comb begin
        shown = disp;
`ifdef DISP_SCAN_BLANK_EN
        begin
            logic lead;
            lead = 1'b1;
            for (int i = int'(DIGITS) - 1; i > 0; i--) begin
                lead = lead && (disp[i] == '0);
                if (lead) begin
                    shown[i] = BLANK_CODE;
                end
            end
        end
`endif
    end

    // Scan prescaler, digit index, decoder strobe and anode drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre   <= '0;
            idx   <= '0;
            bcd_q <= 4'h0;
            ce_q  <= 1'b0;
            an_q  <= '1;
        end else begin
            ce_q <= 1'b0;
            if (ce_q) begin
                an_q <= ~(DIGITS'(1) << idx);
            end
            if (pre == PRE_W'(SCAN_DIV - 1)) begin
                pre   <= '0;
                idx   <= idx_nxt;
                bcd_q <= shown[idx_nxt];
                ce_q  <= 1'b1;
            end else begin
                pre <= pre + PRE_W'(1);
            end
        end
    end

    assign bus.busy = conv_busy;
    assign bus.bcd  = bcd_q;
    assign bus.ce   = ce_q;
    assign bus.an   = an_q;

endmodule

// File: tb/tb_disp_scan.sv
// Directed self-checking bench for disp_scan with SCAN_DIV=4.
module tb_disp_scan;
    import disp_pkg::*;

    localparam int unsigned SCAN_DIV = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared   = 0;
    int   mismatched = 0;
    int   ce_seen    = 0;
    logic [3:0] exp_d [DIGITS];

    disp_scan_if bus ();

    disp_scan #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Count completed decoder strobes since reset; gives the digit index expected next.
    always @(posedge clk) begin
        if (rst) ce_seen <= 0;
        else if (bus.ce) ce_seen <= ce_seen + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [3:0] an_for(input int i);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << i);
    endfunction

    task automatic set_exp(input logic [3:0] d3, input logic [3:0] d2,
                           input logic [3:0] d1, input logic [3:0] d0);
        exp_d[3] = d3; exp_d[2] = d2; exp_d[1] = d1; exp_d[0] = d0;
    endtask

    // Pulse load for one cycle; returns at the negedge of busy cycle 1.
    task automatic do_load(input logic [13:0] v);
        @(negedge clk);
        bus.value = v;
        bus.load  = 1'b1;
        @(negedge clk);
        bus.load  = 1'b0;
    endtask

    task automatic wait_idle(output int n, output bit to);
        n = 0;
        while (bus.busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        to = bus.busy;
    endtask

    // Observe one scan step: bcd during ce, then ce/an one cycle later.
    task automatic observe_step(output logic [3:0] b, output logic [3:0] a, output int idx,
                                output int gap, output logic ce_after, output bit to);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!bus.ce && gap < int'(4 * SCAN_DIV + 4));
        to  = !bus.ce;
        b   = bus.bcd;
        idx = (ce_seen + 1) % 4;
        @(negedge clk);
        ce_after = bus.ce;
        a        = bus.an;
    endtask

    task automatic test_reset();
        bus.value = '0;
        bus.load  = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        compared++; if (bus.bcd !== 4'h0) begin mismatched++; $display("FAIL reset_bcd: got %h expected 0", bus.bcd); end
        compared++; if (bus.ce !== 1'b0) begin mismatched++; $display("FAIL reset_ce: got %b expected 0", bus.ce); end
        compared++; if (bus.an !== 4'b1111) begin mismatched++; $display("FAIL reset_an: got %b expected 1111", bus.an); end
        rst = 1'b0;
        @(negedge clk);
        compared++; if (bus.an !== 4'b1111 || bus.ce !== 1'b0) begin mismatched++; $display("FAIL reset_release: got an=%b ce=%b expected 1111/0", bus.an, bus.ce); end
    endtask

    task automatic test_convert();
        int n; bit to; logic [3:0] b, a; int idx, gap; logic ce_after;
        set_exp(4'd1, 4'd2, 4'd3, 4'd4);
        do_load(14'd1234);
        compared++; if (bus.busy !== 1'b1) begin mismatched++; $display("FAIL convert_busy_rise: got %b expected 1", bus.busy); end
        wait_idle(n, to);
        compared++; if (to || n != 14) begin mismatched++; $display("FAIL convert_busy_len: got %0d expected 14", n); end
        for (int k = 0; k < 8; k++) begin
            observe_step(b, a, idx, gap, ce_after, to);
            compared++;
            if (to) begin mismatched++; $display("FAIL convert_ce_timeout: got no ce expected ce"); end
            else if (b !== exp_d[idx]) begin mismatched++; $display("FAIL convert_bcd[%0d]: got %h expected %h", idx, b, exp_d[idx]); end
            compared++; if (a !== an_for(idx)) begin mismatched++; $display("FAIL convert_an[%0d]: got %b expected %b", idx, a, an_for(idx)); end
            if (k > 0) begin
                compared++; if (gap != int'(SCAN_DIV) - 1) begin mismatched++; $display("FAIL convert_ce_spacing: got %0d expected %0d", gap + 1, SCAN_DIV); end
            end
        end
    endtask

    task automatic test_clamp();
        int n; bit to; logic [3:0] b, a; int idx, gap; logic ce_after;
        set_exp(4'd9, 4'd9, 4'd9, 4'd9);
        do_load(14'd16383);
        wait_idle(n, to);
        compared++; if (to || n != 14) begin mismatched++; $display("FAIL clamp_busy_len: got %0d expected 14", n); end
        for (int k = 0; k < 4; k++) begin
            observe_step(b, a, idx, gap, ce_after, to);
            compared++;
            if (to || b !== exp_d[idx]) begin mismatched++; $display("FAIL clamp_bcd[%0d]: got %h expected %h", idx, b, exp_d[idx]); end
        end
    endtask

    task automatic test_load_ignored();
        int n; bit to; logic [3:0] b, a; int idx, gap; logic ce_after;
`ifdef DISP_SCAN_BLANK_EN
        set_exp(4'hF, 4'hF, 4'd4, 4'd2);
`else
        set_exp(4'd0, 4'd0, 4'd4, 4'd2);
`endif
        do_load(14'd42);
        repeat (4) @(negedge clk);
        bus.value = 14'd7;
        bus.load  = 1'b1;
        @(negedge clk);
        bus.load  = 1'b0;
        wait_idle(n, to);
        compared++; if (to || n + 5 != 14) begin mismatched++; $display("FAIL ignore_busy_len: got %0d expected 14", n + 5); end
        @(negedge clk);
        compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL ignore_no_restart: got %b expected 0", bus.busy); end
        for (int k = 0; k < 4; k++) begin
            observe_step(b, a, idx, gap, ce_after, to);
            compared++;
            if (to || b !== exp_d[idx]) begin mismatched++; $display("FAIL ignore_bcd[%0d]: got %h expected %h", idx, b, exp_d[idx]); end
        end
    endtask

    task automatic test_reset_abort();
        int n; bit to; bit rose; logic [3:0] b, a; int idx, gap; logic ce_after;
`ifdef DISP_SCAN_BLANK_EN
        set_exp(4'hF, 4'hF, 4'hF, 4'd0);
`else
        set_exp(4'd0, 4'd0, 4'd0, 4'd0);
`endif
        do_load(14'd500);
        repeat (7) @(negedge clk);
        compared++; if (bus.busy !== 1'b1) begin mismatched++; $display("FAIL abort_busy_cycle8: got %b expected 1", bus.busy); end
        rst = 1'b1;
        @(negedge clk);
        compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
        compared++; if (bus.an !== 4'b1111) begin mismatched++; $display("FAIL abort_an: got %b expected 1111", bus.an); end
        compared++; if (bus.bcd !== 4'h0) begin mismatched++; $display("FAIL abort_bcd: got %h expected 0", bus.bcd); end
        rst = 1'b0;
        rose = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.busy !== 1'b0) rose = 1'b1;
        end
        compared++; if (rose) begin mismatched++; $display("FAIL abort_busy_stays_low: got 1 expected 0"); end
        for (int k = 0; k < 4; k++) begin
            observe_step(b, a, idx, gap, ce_after, to);
            compared++;
            if (to || b !== exp_d[idx]) begin mismatched++; $display("FAIL abort_bcd[%0d]: got %h expected %h", idx, b, exp_d[idx]); end
        end
    endtask

    task automatic test_blank();
        logic [13:0] vals [3];
        int n; bit to; logic [3:0] b, a; int idx, gap; logic ce_after;
        vals[0] = 14'd0; vals[1] = 14'd7; vals[2] = 14'd1000;
        for (int v = 0; v < 3; v++) begin
`ifdef DISP_SCAN_BLANK_EN
            if (v == 0) set_exp(4'hF, 4'hF, 4'hF, 4'd0);
            else if (v == 1) set_exp(4'hF, 4'hF, 4'hF, 4'd7);
            else set_exp(4'd1, 4'd0, 4'd0, 4'd0);
`else
            if (v == 0) set_exp(4'd0, 4'd0, 4'd0, 4'd0);
            else if (v == 1) set_exp(4'd0, 4'd0, 4'd0, 4'd7);
            else set_exp(4'd1, 4'd0, 4'd0, 4'd0);
`endif
            do_load(vals[v]);
            wait_idle(n, to);
            for (int k = 0; k < 4; k++) begin
                observe_step(b, a, idx, gap, ce_after, to);
                compared++;
                if (to || b !== exp_d[idx]) begin mismatched++; $display("FAIL blank_%0d_bcd[%0d]: got %h expected %h", vals[v], idx, b, exp_d[idx]); end
            end
        end
    endtask

    task automatic test_free_run();
        bit to; logic [3:0] b, a; int idx, gap; logic ce_after;
        int bad_gap, bad_width, bad_an, bad_bcd;
        bad_gap = 0; bad_width = 0; bad_an = 0; bad_bcd = 0;
        for (int k = 0; k < 100; k++) begin
            observe_step(b, a, idx, gap, ce_after, to);
            if (to) begin
                compared++; mismatched++;
                $display("FAIL free_run_timeout: got no ce expected ce at step %0d", k);
                break;
            end
            if (k > 0 && gap != int'(SCAN_DIV) - 1) bad_gap++;
            if (ce_after !== 1'b0) bad_width++;
            if ($countones(~a) != 1 || a !== an_for(idx)) bad_an++;
            if (b !== exp_d[idx]) bad_bcd++;
        end
        compared++; if (bad_gap != 0) begin mismatched++; $display("FAIL free_run_spacing: got %0d bad gaps expected 0", bad_gap); end
        compared++; if (bad_width != 0) begin mismatched++; $display("FAIL free_run_ce_width: got %0d wide pulses expected 0", bad_width); end
        compared++; if (bad_an != 0) begin mismatched++; $display("FAIL free_run_an: got %0d bad selects expected 0", bad_an); end
        compared++; if (bad_bcd != 0) begin mismatched++; $display("FAIL free_run_bcd: got %0d bad digits expected 0", bad_bcd); end
    endtask

    task automatic test_rst_over_load();
        bit to; logic [3:0] b, a; int idx, gap; logic ce_after;
`ifdef DISP_SCAN_BLANK_EN
        set_exp(4'hF, 4'hF, 4'hF, 4'd0);
`else
        set_exp(4'd0, 4'd0, 4'd0, 4'd0);
`endif
        @(negedge clk);
        rst       = 1'b1;
        bus.value = 14'd1234;
        bus.load  = 1'b1;
        @(negedge clk);
        compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL rst_prio_busy: got %b expected 0", bus.busy); end
        rst      = 1'b0;
        bus.load = 1'b0;
        @(negedge clk);
        compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL rst_prio_busy_after: got %b expected 0", bus.busy); end
        for (int k = 0; k < 4; k++) begin
            observe_step(b, a, idx, gap, ce_after, to);
            compared++;
            if (to || b !== exp_d[idx]) begin mismatched++; $display("FAIL rst_prio_bcd[%0d]: got %h expected %h", idx, b, exp_d[idx]); end
        end
    endtask

    initial begin
        test_reset();
        test_convert();
        test_clamp();
        test_load_ignored();
        test_reset_abort();
        test_blank();
        test_free_run();
        test_rst_over_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/disp_scan.md
DISP_SCAN -- requirements
Module: disp_scan

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clk cycles per digit slot; legal range >= 2.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 value  input  14  unsigned binary value to display.
REQ-005 load  input  1  single-cycle strobe; samples value.
REQ-006 busy  output  1  high while a conversion is in progress.
REQ-007 bcd  output  4  digit code for the downstream 7-segment decoder bcd input.
REQ-008 ce  output  1  one-cycle enable for the downstream decoder ce input.
REQ-009 an  output  4  digit anode selects, active-low; an[0] = units.

Function
REQ-010 On load=1 with busy=0, the block SHALL capture min(value, 9999), clear the working BCD accumulator, set busy on the next edge and start a 14-step sequential shift-add-3 conversion.
REQ-011 Each busy cycle SHALL apply add-3 to every working nibble >= 5, then shift left one bit with the next binary MSB entering.
REQ-012 busy SHALL be high for exactly 14 cycles; on the edge ending the 14th busy cycle, the four display digit registers SHALL update atomically and busy SHALL fall.
REQ-013 load asserted while busy=1 SHALL be ignored; no queueing.
REQ-014 Display digit registers SHALL hold their value during conversion; no partial result is ever shown.
REQ-015 A prescaler SHALL count 0..SCAN_DIV-1 and wrap; at wrap the digit index SHALL advance 0->1->2->3->0.
REQ-016 On the edge after the prescaler reaches SCAN_DIV-1, bcd SHALL take the digit at the new index and ce SHALL be 1 for exactly that one cycle.
REQ-017 an SHALL update on the edge that ends the ce cycle, to a one-hot-low select of the new index, so the anode switches on the same edge at which the decoder latches its segments.
REQ-018 ce SHALL pulse exactly once per SCAN_DIV cycles; bcd SHALL be stable during ce.
REQ-019 A conversion completing on the same edge as a scan step SHALL let that scan step read the pre-update digits; new digits appear from the next scan step.

Reset
REQ-020 While rst=1: busy=0, bcd=4'h0, ce=0, an=4'b1111, digit registers=0, index=0, prescaler=0.
REQ-021 rst asserted mid-conversion SHALL abort the conversion; no digit update occurs.
REQ-022 rst SHALL take priority over load in the same cycle.

Configuration
REQ-023 Macro DISP_SCAN_BLANK_EN: when defined, digits above the most significant nonzero digit SHALL be output as 4'hF (blank code); the units digit is never blanked, so value 0 shows one "0".
REQ-024 When DISP_SCAN_BLANK_EN is undefined, all four digits SHALL be shown, including leading zeros.

Structure
REQ-025 Shared package disp_pkg SHALL hold: DIGITS=4, BIN_W=14, MAX_VAL=9999, BLANK_CODE=4'hF, and the digit-nibble array typedef.
REQ-026 The conversion engine SHALL be sub-module bin2bcd_seq (ports clk, rst, start, bin, busy, done, digits); disp_scan holds clamping, the display registers, the scan logic and blanking.

Verification (SCAN_DIV=4)
REQ-027 load value=1234 -> busy high exactly 14 cycles; scan then produces bcd 4,3,2,1 with an 1110,1101,1011,0111; ce once every 4 cycles.
REQ-028 load value=16383 -> displayed digits 9,9,9,9 (clamped).
REQ-029 load value=42, then load value=7 during cycle 5 of busy -> second load ignored; display shows 0042 (or F,F,4,2 with DISP_SCAN_BLANK_EN).
REQ-030 rst pulsed during busy cycle 8 after load value=500 -> busy=0, an=1111, digits 0; no later update.
REQ-031 DISP_SCAN_BLANK_EN defined, value=0 -> bcd F,F,F,0; value=7 -> F,F,F,7; value=1000 -> no blanking.
REQ-032 Free-running scan over 100 ce pulses -> ce width always 1, spacing always 4, bcd stable during every ce, exactly one an bit low after the first scan step.
